// File: rtl/rv_mem_arb_if.sv
// Bus bundle for rv_mem_arb: two requesters (core, external) and one memory port.
// slave modport: the arbiter's view (requests and memory read data in; acks and memory controls out).
// master modport: the requesters' and memory's view, with the same directions reversed.
interface rv_mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Core requester
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_ack;
  // External (loader/debug) requester
  logic              e_req;
  logic              e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  logic              e_ack;
  // Read data returned to whichever requester is acknowledged
  logic [DATA_W-1:0] rdata;
  // Memory port
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  // Status
  logic              busy;
  logic              gnt_ext;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  e_req, e_we, e_addr, e_wdata,
    input  m_rdata,
    output c_ack, e_ack, rdata,
    output m_en, m_we, m_addr, m_wdata,
    output busy, gnt_ext
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output e_req, e_we, e_addr, e_wdata,
    output m_rdata,
    input  c_ack, e_ack, rdata,
    input  m_en, m_we, m_addr, m_wdata,
    input  busy, gnt_ext
  );
endinterface

// File: rtl/rv_mem_arb.sv
// Two-requester (core / external) round-robin arbiter for a single fixed-latency memory port.
// Latency: a request sampled in IDLE at cycle N gets m_en in N+1..N+MEM_LAT, ack at N+MEM_LAT+1.
// Backpressure: requesters hold req until their one-cycle ack; requests are sampled only in IDLE.
// Ports: clk, rst (async, active-high); bus (rv_mem_arb_if.slave) carrying c_*/e_* requester
//   handshakes, rdata, the m_* memory port, and busy/gnt_ext status. MEM_LAT legal range 1..15.
module rv_mem_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic         clk,
  input logic         rst,
  rv_mem_arb_if.slave bus
);

  // Counter loads MEM_LAT-1 so that ACCESS spans exactly MEM_LAT cycles (it leaves at count 0).
  localparam logic [3:0] LP_CNT_LOAD = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              r_state,    w_state_nxt;
  logic [3:0]          r_cnt,      w_cnt_nxt;
  logic                r_last_ext, w_last_ext_nxt;  // winner of the previous completed grant
  logic                r_win_ext,  w_win_ext_nxt;   // owner of the grant in flight
  logic                r_we,       w_we_nxt;
  logic [ADDR_W-1:0]   r_addr,     w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata,    w_wdata_nxt;
  logic [DATA_W-1:0]   r_rdata,    w_rdata_nxt;

  logic                w_grant_ext;
  logic                w_m_en;
  logic                w_m_we;
  logic [ADDR_W-1:0]   w_m_addr;
  logic [DATA_W-1:0]   w_m_wdata;
  logic                w_c_ack;
  logic                w_e_ack;
  logic                w_busy;
  logic                w_gnt_ext;

  // External wins if it is the only requester, or on a tie when the core won last time.
  assign w_grant_ext = bus.e_req && (!bus.c_req || !r_last_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_last_ext <= 1'b1;  // core wins the first tie after reset
      r_win_ext  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_last_ext <= w_last_ext_nxt;
      r_win_ext  <= w_win_ext_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_rdata    <= w_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_last_ext_nxt = r_last_ext;
    w_win_ext_nxt  = r_win_ext;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_rdata_nxt    = r_rdata;
    w_m_en         = 1'b0;
    w_m_we         = 1'b0;
    w_m_addr       = '0;
    w_m_wdata      = '0;
    w_c_ack        = 1'b0;
    w_e_ack        = 1'b0;
    w_busy         = 1'b0;
    w_gnt_ext      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.c_req || bus.e_req) begin
          // Snapshot the winner's command so later input changes cannot disturb the access.
          w_win_ext_nxt = w_grant_ext;
          w_we_nxt      = w_grant_ext ? bus.e_we    : bus.c_we;
          w_addr_nxt    = w_grant_ext ? bus.e_addr  : bus.c_addr;
          w_wdata_nxt   = w_grant_ext ? bus.e_wdata : bus.c_wdata;
          w_cnt_nxt     = LP_CNT_LOAD;
          w_state_nxt   = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        w_m_en    = 1'b1;
        w_m_we    = r_we;
        w_m_addr  = r_addr;
        w_m_wdata = r_wdata;
        w_busy    = 1'b1;
        w_gnt_ext = r_win_ext;
        if (r_cnt == 4'd0) begin
          // Memory read data is valid only in the last enable cycle.
          w_rdata_nxt = bus.m_rdata;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      ST_RESP: begin
        w_busy         = 1'b1;
        w_gnt_ext      = r_win_ext;
        w_c_ack        = !r_win_ext;
        w_e_ack        = r_win_ext;
        w_last_ext_nxt = r_win_ext;
        w_state_nxt    = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.m_en    = w_m_en;
  assign bus.m_we    = w_m_we;
  assign bus.m_addr  = w_m_addr;
  assign bus.m_wdata = w_m_wdata;
  assign bus.c_ack   = w_c_ack;
  assign bus.e_ack   = w_e_ack;
  assign bus.rdata   = r_rdata;
  assign bus.busy    = w_busy;
  assign bus.gnt_ext = w_gnt_ext;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Self-checking bench for rv_mem_arb: directed scenarios plus a randomized transaction stream
// checked against a transaction-level round-robin model. Three instances cover MEM_LAT 2, 1, 15.
// The bench plays the memory: read data is a fixed function of address, valid only in the last enable cycle.
module tb_rv_mem_arb;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   nchk;
  int   nerr;

  rv_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) u_if   ();
  rv_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) u_if1  ();
  rv_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) u_if15 ();

  rv_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2))  u_dut   (.clk(clk), .rst(rst), .bus(u_if));
  rv_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1))  u_dut1  (.clk(clk), .rst(rst), .bus(u_if1));
  rv_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(15)) u_dut15 (.clk(clk), .rst(rst), .bus(u_if15));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a pure function of address; 0x40 holds 0xDEADBEEF.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Memory model: counts consecutive enable cycles and only returns real data in the last one.
  int run2, run1, run15;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      run2  <= 0;
      run1  <= 0;
      run15 <= 0;
    end else begin
      run2  <= u_if.m_en   ? run2 + 1  : 0;
      run1  <= u_if1.m_en  ? run1 + 1  : 0;
      run15 <= u_if15.m_en ? run15 + 1 : 0;
    end
  end
  assign u_if.m_rdata   = (u_if.m_en   && run2  == 1)  ? memf(u_if.m_addr)   : 32'hBAD0BAD0;
  assign u_if1.m_rdata  = (u_if1.m_en  && run1  == 0)  ? memf(u_if1.m_addr)  : 32'hBAD0BAD0;
  assign u_if15.m_rdata = (u_if15.m_en && run15 == 14) ? memf(u_if15.m_addr) : 32'hBAD0BAD0;

  // Protocol invariants on every instance, every cycle.
  always @(negedge clk) begin
    assert (!(u_if.c_ack   && u_if.e_ack))   else $error("FAIL ack_mutex lat2 both acks high");
    assert (!(u_if1.c_ack  && u_if1.e_ack))  else $error("FAIL ack_mutex lat1 both acks high");
    assert (!(u_if15.c_ack && u_if15.e_ack)) else $error("FAIL ack_mutex lat15 both acks high");
    assert (!(u_if.m_we   && !u_if.m_en))    else $error("FAIL we_implies_en lat2 m_we without m_en");
    assert (!(u_if1.m_we  && !u_if1.m_en))   else $error("FAIL we_implies_en lat1 m_we without m_en");
    assert (!(u_if15.m_we && !u_if15.m_en))  else $error("FAIL we_implies_en lat15 m_we without m_en");
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    u_if.c_req = 0;   u_if.c_we = 0;   u_if.c_addr = '0;   u_if.c_wdata = '0;
    u_if.e_req = 0;   u_if.e_we = 0;   u_if.e_addr = '0;   u_if.e_wdata = '0;
    u_if1.c_req = 0;  u_if1.c_we = 0;  u_if1.c_addr = '0;  u_if1.c_wdata = '0;
    u_if1.e_req = 0;  u_if1.e_we = 0;  u_if1.e_addr = '0;  u_if1.e_wdata = '0;
    u_if15.c_req = 0; u_if15.c_we = 0; u_if15.c_addr = '0; u_if15.c_wdata = '0;
    u_if15.e_req = 0; u_if15.e_we = 0; u_if15.e_addr = '0; u_if15.e_wdata = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset state: outputs low and rdata cleared, even with a request pending during reset.
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    u_if.c_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      nchk++;
      if ({u_if.busy, u_if.m_en, u_if.m_we, u_if.c_ack, u_if.e_ack, u_if.gnt_ext} !== 6'b0) begin
        nerr++;
        $display("FAIL reset_outputs k=%0d got=%b required=000000", k,
                 {u_if.busy, u_if.m_en, u_if.m_we, u_if.c_ack, u_if.e_ack, u_if.gnt_ext});
      end
      nchk++;
      if (u_if.rdata !== 32'h0) begin
        nerr++;
        $display("FAIL reset_rdata got=%h required=0", u_if.rdata);
      end
    end
    u_if.c_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    nchk++;
    if (u_if.busy !== 1'b0 || u_if.m_en !== 1'b0 || u_if.m_addr !== '0) begin
      nerr++;
      $display("FAIL idle_after_reset busy=%b m_en=%b m_addr=%h required 0/0/0",
               u_if.busy, u_if.m_en, u_if.m_addr);
    end
  endtask

  // Single core read at 0x40 returning 0xDEADBEEF.
  task automatic test_core_read();
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      nchk++;
      if (u_if.m_en !== (k == 1 || k == 2)) begin
        nerr++;
        $display("FAIL core_read_m_en cycle=%0d got=%b", k, u_if.m_en);
      end
      nchk++;
      if (u_if.c_ack !== (k == 3) || u_if.e_ack !== 1'b0) begin
        nerr++;
        $display("FAIL core_read_ack cycle=%0d c_ack=%b e_ack=%b required c_ack=%b", k, u_if.c_ack, u_if.e_ack, k == 3);
      end
      if (k == 1 || k == 2) begin
        nchk++;
        if (u_if.m_addr !== 32'h40 || u_if.m_we !== 1'b0) begin
          nerr++;
          $display("FAIL core_read_addr cycle=%0d m_addr=%h m_we=%b required 40/0", k, u_if.m_addr, u_if.m_we);
        end
      end
      if (k == 3) begin
        nchk++;
        if (u_if.rdata !== 32'hDEADBEEF) begin
          nerr++;
          $display("FAIL core_read_rdata got=%h required=deadbeef", u_if.rdata);
        end
      end
      if (k == 4) begin
        nchk++;
        if (u_if.busy !== 1'b0) begin
          nerr++;
          $display("FAIL core_read_busy_end got=%b required=0", u_if.busy);
        end
      end
      if (k == 0) begin
        u_if.c_req = 1'b1; u_if.c_we = 1'b0; u_if.c_addr = 32'h40;
      end
      if (k == 3) u_if.c_req = 1'b0;
    end
  endtask

  // Both requesting after reset: core, external, core at cycles 3, 7, 11.
  task automatic test_tie_rr();
    pulse_reset();
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      nchk++;
      if (u_if.c_ack !== (k == 3 || k == 11) || u_if.e_ack !== (k == 7)) begin
        nerr++;
        $display("FAIL tie_rr_acks cycle=%0d c_ack=%b e_ack=%b required %b/%b",
                 k, u_if.c_ack, u_if.e_ack, (k == 3 || k == 11), (k == 7));
      end
      nchk++;
      if (u_if.gnt_ext !== (k >= 5 && k <= 7)) begin
        nerr++;
        $display("FAIL tie_rr_gnt_ext cycle=%0d got=%b required=%b", k, u_if.gnt_ext, (k >= 5 && k <= 7));
      end
      if (k == 0) begin
        u_if.c_req = 1'b1; u_if.c_we = 1'b0; u_if.c_addr = 32'h10;
        u_if.e_req = 1'b1; u_if.e_we = 1'b0; u_if.e_addr = 32'h20;
      end
      if (k == 11) begin
        u_if.c_req = 1'b0;
        u_if.e_req = 1'b0;
      end
    end
  endtask

  // External write of 0x12345678 to 0x100.
  task automatic test_ext_write();
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      nchk++;
      if (u_if.m_we !== (k == 1 || k == 2) || u_if.m_en !== (k == 1 || k == 2)) begin
        nerr++;
        $display("FAIL ext_write_we cycle=%0d m_en=%b m_we=%b", k, u_if.m_en, u_if.m_we);
      end
      nchk++;
      if (u_if.gnt_ext !== (k >= 1 && k <= 3)) begin
        nerr++;
        $display("FAIL ext_write_gnt cycle=%0d got=%b required=%b", k, u_if.gnt_ext, (k >= 1 && k <= 3));
      end
      nchk++;
      if (u_if.e_ack !== (k == 3) || u_if.c_ack !== 1'b0) begin
        nerr++;
        $display("FAIL ext_write_ack cycle=%0d e_ack=%b c_ack=%b", k, u_if.e_ack, u_if.c_ack);
      end
      if (k == 1 || k == 2) begin
        nchk++;
        if (u_if.m_addr !== 32'h100 || u_if.m_wdata !== 32'h12345678) begin
          nerr++;
          $display("FAIL ext_write_bus cycle=%0d m_addr=%h m_wdata=%h required 100/12345678",
                   k, u_if.m_addr, u_if.m_wdata);
        end
      end
      if (k == 0) begin
        u_if.e_req = 1'b1; u_if.e_we = 1'b1; u_if.e_addr = 32'h100; u_if.e_wdata = 32'h12345678;
      end
      if (k == 3) begin
        u_if.e_req = 1'b0; u_if.e_we = 1'b0;
      end
    end
  endtask

  // Inputs change (and req drops) right after the grant: access and ack are unaffected.
  task automatic test_input_change();
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1 || k == 2) begin
        nchk++;
        if (u_if.m_addr !== 32'h40 || u_if.m_we !== 1'b0 || u_if.m_en !== 1'b1) begin
          nerr++;
          $display("FAIL input_change_bus cycle=%0d m_addr=%h m_we=%b m_en=%b required 40/0/1",
                   k, u_if.m_addr, u_if.m_we, u_if.m_en);
        end
      end
      nchk++;
      if (u_if.c_ack !== (k == 3)) begin
        nerr++;
        $display("FAIL input_change_ack cycle=%0d got=%b required=%b", k, u_if.c_ack, k == 3);
      end
      if (k == 3) begin
        nchk++;
        if (u_if.rdata !== 32'hDEADBEEF) begin
          nerr++;
          $display("FAIL input_change_rdata got=%h required=deadbeef", u_if.rdata);
        end
      end
      if (k == 4) begin
        nchk++;
        if (u_if.busy !== 1'b0) begin
          nerr++;
          $display("FAIL input_change_no_regrant busy=%b required=0", u_if.busy);
        end
      end
      if (k == 0) begin
        u_if.c_req = 1'b1; u_if.c_we = 1'b0; u_if.c_addr = 32'h40;
      end
      if (k == 1) begin
        u_if.c_addr = 32'h80; u_if.c_we = 1'b1; u_if.c_req = 1'b0;
      end
    end
    u_if.c_we = 1'b0;
  endtask

  // Reset during ACCESS aborts without ack; a held request completes after reset.
  task automatic test_reset_mid();
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k == 2) begin
        rst = 1'b1;
        #1;
        nchk++;
        if (u_if.m_en !== 1'b0 || u_if.busy !== 1'b0 || u_if.c_ack !== 1'b0) begin
          nerr++;
          $display("FAIL reset_mid_immediate m_en=%b busy=%b c_ack=%b required 0/0/0",
                   u_if.m_en, u_if.busy, u_if.c_ack);
        end
      end else begin
        nchk++;
        if (u_if.c_ack !== (k == 6)) begin
          nerr++;
          $display("FAIL reset_mid_ack cycle=%0d got=%b required=%b", k, u_if.c_ack, k == 6);
        end
        if (k == 4 || k == 5) begin
          nchk++;
          if (u_if.m_en !== 1'b1 || u_if.m_addr !== 32'h40) begin
            nerr++;
            $display("FAIL reset_mid_reaccess cycle=%0d m_en=%b m_addr=%h", k, u_if.m_en, u_if.m_addr);
          end
        end
        if (k == 6) begin
          nchk++;
          if (u_if.rdata !== 32'hDEADBEEF) begin
            nerr++;
            $display("FAIL reset_mid_rdata got=%h required=deadbeef", u_if.rdata);
          end
        end
      end
      if (k == 0) begin
        u_if.c_req = 1'b1; u_if.c_we = 1'b0; u_if.c_addr = 32'h40;
      end
      if (k == 3) rst = 1'b0;
      if (k == 6) u_if.c_req = 1'b0;
    end
  endtask

  // MEM_LAT=1 and MEM_LAT=15 side by side: core reads, then external writes.
  task automatic test_lat_sweep();
    logic [31:0] a1, a15, d1, d15;
    for (int pass = 0; pass < 2; pass++) begin
      a1  = 32'($urandom_range(0, 63)) << 2;
      a15 = 32'($urandom_range(0, 63)) << 2;
      d1  = $urandom;
      d15 = $urandom;
      for (int k = 0; k <= 17; k++) begin
        @(negedge clk);
        nchk++;
        if (u_if1.m_en !== (k == 1) || u_if1.m_we !== (pass == 1 && k == 1)) begin
          nerr++;
          $display("FAIL lat1_en pass=%0d cycle=%0d m_en=%b m_we=%b", pass, k, u_if1.m_en, u_if1.m_we);
        end
        nchk++;
        if (u_if15.m_en !== (k >= 1 && k <= 15) || u_if15.m_we !== (pass == 1 && k >= 1 && k <= 15)) begin
          nerr++;
          $display("FAIL lat15_en pass=%0d cycle=%0d m_en=%b m_we=%b", pass, k, u_if15.m_en, u_if15.m_we);
        end
        nchk++;
        if (u_if1.c_ack !== (pass == 0 && k == 2) || u_if1.e_ack !== (pass == 1 && k == 2)) begin
          nerr++;
          $display("FAIL lat1_ack pass=%0d cycle=%0d c_ack=%b e_ack=%b", pass, k, u_if1.c_ack, u_if1.e_ack);
        end
        nchk++;
        if (u_if15.c_ack !== (pass == 0 && k == 16) || u_if15.e_ack !== (pass == 1 && k == 16)) begin
          nerr++;
          $display("FAIL lat15_ack pass=%0d cycle=%0d c_ack=%b e_ack=%b", pass, k, u_if15.c_ack, u_if15.e_ack);
        end
        if (pass == 0 && k == 2) begin
          nchk++;
          if (u_if1.rdata !== memf(a1)) begin
            nerr++;
            $display("FAIL lat1_rdata got=%h required=%h", u_if1.rdata, memf(a1));
          end
        end
        if (pass == 0 && k == 16) begin
          nchk++;
          if (u_if15.rdata !== memf(a15)) begin
            nerr++;
            $display("FAIL lat15_rdata got=%h required=%h", u_if15.rdata, memf(a15));
          end
        end
        if (pass == 1 && k == 8) begin
          nchk++;
          if (u_if15.m_addr !== a15 || u_if15.m_wdata !== d15) begin
            nerr++;
            $display("FAIL lat15_wbus m_addr=%h m_wdata=%h required %h/%h", u_if15.m_addr, u_if15.m_wdata, a15, d15);
          end
        end
        if (k == 0) begin
          if (pass == 0) begin
            u_if1.c_req = 1'b1;  u_if1.c_we = 1'b0;  u_if1.c_addr = a1;
            u_if15.c_req = 1'b1; u_if15.c_we = 1'b0; u_if15.c_addr = a15;
          end else begin
            u_if1.e_req = 1'b1;  u_if1.e_we = 1'b1;  u_if1.e_addr = a1;  u_if1.e_wdata = d1;
            u_if15.e_req = 1'b1; u_if15.e_we = 1'b1; u_if15.e_addr = a15; u_if15.e_wdata = d15;
          end
        end
        if (k == 2)  begin u_if1.c_req = 1'b0;  u_if1.e_req = 1'b0;  end
        if (k == 16) begin u_if15.c_req = 1'b0; u_if15.e_req = 1'b0; end
      end
    end
  endtask

  // Random transaction stream against a round-robin model; inputs scrambled during each access.
  task automatic test_random();
    localparam int LAT = 2;
    logic        m_last_ext;
    logic        c, e, win_ext, x_we;
    logic [31:0] x_addr, x_wdata;
    int          sel;
    pulse_reset();
    m_last_ext = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      nchk++;
      if (u_if.busy !== 1'b0 || u_if.m_en !== 1'b0 || u_if.m_addr !== '0 || u_if.m_wdata !== '0) begin
        nerr++;
        $display("FAIL rand_idle t=%0d busy=%b m_en=%b m_addr=%h m_wdata=%h", t, u_if.busy, u_if.m_en, u_if.m_addr, u_if.m_wdata);
      end
      sel = int'($urandom_range(0, 3));
      c = sel[0];
      e = sel[1];
      u_if.c_req = c; u_if.c_we = 1'($urandom); u_if.c_addr = 32'($urandom_range(0, 63)) << 2; u_if.c_wdata = $urandom;
      u_if.e_req = e; u_if.e_we = 1'($urandom); u_if.e_addr = 32'($urandom_range(0, 63)) << 2; u_if.e_wdata = $urandom;
      if (!c && !e) continue;
      win_ext = e && (!c || !m_last_ext);
      x_we    = win_ext ? u_if.e_we    : u_if.c_we;
      x_addr  = win_ext ? u_if.e_addr  : u_if.c_addr;
      x_wdata = win_ext ? u_if.e_wdata : u_if.c_wdata;
      for (int k = 1; k <= LAT; k++) begin
        @(negedge clk);
        nchk++;
        if (u_if.m_en !== 1'b1 || u_if.m_we !== x_we || u_if.m_addr !== x_addr || u_if.m_wdata !== x_wdata) begin
          nerr++;
          $display("FAIL rand_access t=%0d k=%0d en=%b we=%b addr=%h wdata=%h required 1/%b/%h/%h",
                   t, k, u_if.m_en, u_if.m_we, u_if.m_addr, u_if.m_wdata, x_we, x_addr, x_wdata);
        end
        nchk++;
        if (u_if.gnt_ext !== win_ext || u_if.c_ack !== 1'b0 || u_if.e_ack !== 1'b0) begin
          nerr++;
          $display("FAIL rand_owner t=%0d k=%0d gnt_ext=%b c_ack=%b e_ack=%b required gnt_ext=%b",
                   t, k, u_if.gnt_ext, u_if.c_ack, u_if.e_ack, win_ext);
        end
        u_if.c_req = 1'($urandom); u_if.c_we = 1'($urandom); u_if.c_addr = $urandom; u_if.c_wdata = $urandom;
        u_if.e_req = 1'($urandom); u_if.e_we = 1'($urandom); u_if.e_addr = $urandom; u_if.e_wdata = $urandom;
      end
      @(negedge clk);
      nchk++;
      if (u_if.c_ack !== !win_ext || u_if.e_ack !== win_ext || u_if.m_en !== 1'b0) begin
        nerr++;
        $display("FAIL rand_ack t=%0d c_ack=%b e_ack=%b m_en=%b required %b/%b/0",
                 t, u_if.c_ack, u_if.e_ack, u_if.m_en, !win_ext, win_ext);
      end
      if (!x_we) begin
        nchk++;
        if (u_if.rdata !== memf(x_addr)) begin
          nerr++;
          $display("FAIL rand_rdata t=%0d got=%h required=%h", t, u_if.rdata, memf(x_addr));
        end
      end
      m_last_ext = win_ext;
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    test_reset();
    test_core_read();
    test_tie_rr();
    test_ext_write();
    test_input_change();
    test_reset_mid();
    test_lat_sweep();
    test_random();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
